uart_rx_param: RTL and testbench

Parametrised UART receiver with runtime-programmable baud divisor. It supports configurable data width, optional parity and one or two stop bits, and rejects glitches on the start bit. Received characters are buffered in a small FIFO that carries per-character framing and parity error flags. The block sits between the board RX pin and the command/telemetry processing logic, which drains it with a pop handshake.

---
 rtl/uart_rx_param_if.sv | 43 ++++
 rtl/uart_rx_param.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Receive-side bundle for uart_rx_param.
// slave = receiver, master = host draining the FIFO.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8,
  parameter int BAUD_W    = 16
);
  logic                 RX;
  logic [BAUD_W-1:0]    baud_cnt;
  logic                 rd_en;
  logic                 clr_ovr;
  logic [DATA_BITS-1:0] rx_data;
  logic                 frm_err;
  logic                 par_err;
  logic                 rdy;
  logic                 overrun;
  logic                 busy;

  modport slave (
    input  RX,
    input  baud_cnt,
    input  rd_en,
    input  clr_ovr,
    output rx_data,
    output frm_err,
    output par_err,
    output rdy,
    output overrun,
    output busy
  );

  modport master (
    output RX,
    output baud_cnt,
    output rd_en,
    output clr_ovr,
    input  rx_data,
    input  frm_err,
    input  par_err,
    input  rdy,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// UART receiver, runtime baud divisor, glitch-
// rejecting start, FWFT FIFO with error flags.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_W     = 16
) (
  input logic            clk,
  input logic            rst_n,
  uart_rx_param_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
  localparam logic       ODD    = 1'(PARITY_ODD);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PARITY  = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;

  logic                 rx_m;
  logic                 rx_s;
  logic [2:0]           state;
  logic [BAUD_W-1:0]    timer;
  logic [BAUD_W-1:0]    bc_q;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 frm_bad;
  logic                 tick;
  logic                 timing;
  logic                 frm_fin;
  logic                 last_stop;
  logic                 push;
  logic                 pop;
  logic                 wr;
  logic                 full;
  logic                 empty;
  logic [EW-1:0]        push_word;
  logic [EW-1:0]        head;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [PW:0]          wp;
  logic [PW:0]          rp;

  assign tick      = (timer == '0);
  assign timing    = (state != S_IDLE) &&
                     (state != S_WAIT_HI);
  assign frm_fin   = frm_bad | ~rx_s;
  assign last_stop = (bit_cnt == LAST_S);
  assign push      = (state == S_STOP) && tick &&
                     last_stop;
  assign push_word = {par_bad, frm_fin, shreg};

  // Two-flop synchronizer; idle-high reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.RX;
      rx_s <= rx_m;
    end
  end

  // Frame FSM, bit timer and data/flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      timer   <= '0;
      bc_q    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
      frm_bad <= 1'b0;
    end else begin
      if (timing) begin
        timer <= tick ? bc_q : timer - 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          if (!rx_s) begin
            timer   <= bus.baud_cnt >> 1;
            bc_q    <= bus.baud_cnt;
            bit_cnt <= '0;
            par_bad <= 1'b0;
            frm_bad <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            state <= rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_D) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ?
                         S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            par_bad <= ((^shreg) ^ rx_s) != ODD;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            frm_bad <= frm_fin;
            if (last_stop) begin
              state <= frm_fin ? S_WAIT_HI : S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_WAIT_HI: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) &&
                 (wp[PW-1:0] == rp[PW-1:0]);
  assign pop   = bus.rd_en && !empty;
  // A pop in the same cycle frees the slot being written.
  assign wr    = push && (!full || pop);

  // FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
    end
  end

  // FIFO storage; contents masked on read when empty.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wp[PW-1:0]] <= push_word;
    end
  end

  // Sticky overrun; a new drop beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.overrun <= 1'b0;
    end else if (push && full && !pop) begin
      bus.overrun <= 1'b1;
    end else if (bus.clr_ovr) begin
      bus.overrun <= 1'b0;
    end
  end

  assign head        = mem[rp[PW-1:0]];
  assign bus.rx_data = empty ? '0 : head[DATA_BITS-1:0];
  assign bus.frm_err = !empty && head[DATA_BITS];
  assign bus.par_err = !empty && head[DATA_BITS+1];
  assign bus.rdy     = !empty;
  assign bus.busy    = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: 8N1 receiver (a) and
// 8E2 receiver (b), baud_cnt = 15.
module tb_uart_rx_param;

  localparam int BT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] qa [$];
  logic [9:0] qb [$];

  uart_rx_param_if #(.DATA_BITS(8), .BAUD_W(16)) ia ();
  uart_rx_param_if #(.DATA_BITS(8), .BAUD_W(16)) ib ();

  uart_rx_param #(
    .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
    .STOP_BITS(1), .FIFO_DEPTH(4), .BAUD_W(16)
  ) ua (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );

  uart_rx_param #(
    .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
    .STOP_BITS(2), .FIFO_DEPTH(4), .BAUD_W(16)
  ) ub (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) ib.RX = v;
    else     ia.RX = v;
  endtask

  function automatic logic [9:0] head_of(input bit sel);
    if (sel) return {ib.par_err, ib.frm_err, ib.rx_data};
    return {ia.par_err, ia.frm_err, ia.rx_data};
  endfunction

  function automatic logic rdy_of(input bit sel);
    return sel ? ib.rdy : ia.rdy;
  endfunction

  task automatic expect_entry(input bit sel,
                              input logic p,
                              input logic f,
                              input logic [7:0] d);
    if (sel) qb.push_back({p, f, d});
    else     qa.push_back({p, f, d});
  endtask

  task automatic send(input bit sel,
                      input logic [7:0] d,
                      input bit pen,
                      input logic pb,
                      input int ns,
                      input logic [1:0] sv);
    set_rx(sel, 1'b0);
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      repeat (BT) @(negedge clk);
    end
    if (pen) begin
      set_rx(sel, pb);
      repeat (BT) @(negedge clk);
    end
    for (int i = 0; i < ns; i++) begin
      set_rx(sel, sv[i]);
      repeat (BT) @(negedge clk);
    end
    set_rx(sel, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_rd(input bit sel);
    if (sel) ib.rd_en = 1'b1;
    else     ia.rd_en = 1'b1;
    @(negedge clk);
    ib.rd_en = 1'b0;
    ia.rd_en = 1'b0;
  endtask

  task automatic pop_one(input bit sel);
    logic [9:0] e;
    if ((sel ? qb.size() : qa.size()) == 0) begin
      check("extra_rdy", 32'(rdy_of(sel)), 0);
    end else begin
      e = sel ? qb.pop_front() : qa.pop_front();
      check(sel ? "head_b" : "head_a",
            32'(head_of(sel)), 32'(e));
    end
    pulse_rd(sel);
  endtask

  task automatic drain(input bit sel);
    int guard;
    guard = 0;
    while (rdy_of(sel) && guard < 16) begin
      pop_one(sel);
      guard++;
    end
    check("left", sel ? qb.size() : qa.size(), 0);
    check("rdy_after_drain", 32'(rdy_of(sel)), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    ia.RX = 1'b1; ib.RX = 1'b1;
    ia.baud_cnt = 16'd15; ib.baud_cnt = 16'd15;
    ia.rd_en = 1'b0; ib.rd_en = 1'b0;
    ia.clr_ovr = 1'b0; ib.clr_ovr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(ia.rdy), 0);
    check("rst_ovr", 32'(ia.overrun), 0);
    check("rst_busy", 32'(ia.busy), 0);
    check("rst_head", 32'(head_of(0)), 0);
    check("rst_head_b", 32'(head_of(1)), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xA5 with rdy timing around the stop sample
    expect_entry(0, 0, 0, 8'hA5);
    fork
      send(0, 8'hA5, 0, 0, 1, 2'b11);
      begin
        repeat (154) @(negedge clk);
        check("a5_rdy_pre", 32'(ia.rdy), 0);
        @(negedge clk);
        check("a5_rdy_rise", 32'(ia.rdy), 1);
      end
    join
    drain(0);

    // even parity on b, two stop bits
    expect_entry(1, 1, 0, 8'h03);
    send(1, 8'h03, 1, 1, 2, 2'b11);
    expect_entry(1, 0, 0, 8'h03);
    send(1, 8'h03, 1, 0, 2, 2'b11);
    expect_entry(1, 0, 1, 8'h81);
    send(1, 8'h81, 1, 0, 2, 2'b10);
    drain(1);

    // start-bit glitch of 4 clocks
    set_rx(0, 1'b0);
    repeat (4) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (2) @(negedge clk);
    check("glitch_busy", 32'(ia.busy), 1);
    repeat (20) @(negedge clk);
    check("glitch_idle", 32'(ia.busy), 0);
    check("glitch_rdy", 32'(ia.rdy), 0);
    expect_entry(0, 0, 0, 8'h5A);
    send(0, 8'h5A, 0, 0, 1, 2'b11);
    drain(0);

    // break: low for three frame times
    set_rx(0, 1'b0);
    repeat (300) @(negedge clk);
    check("brk_busy", 32'(ia.busy), 1);
    repeat (180) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (10) @(negedge clk);
    check("brk_idle", 32'(ia.busy), 0);
    expect_entry(0, 0, 1, 8'h00);
    drain(0);
    expect_entry(0, 0, 0, 8'h3C);
    send(0, 8'h3C, 0, 0, 1, 2'b11);
    drain(0);

    // overrun: five bytes, no popping
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) expect_entry(0, 0, 0, 8'(i * 17));
      send(0, 8'(i * 17), 0, 0, 1, 2'b11);
    end
    check("ovr_set", 32'(ia.overrun), 1);
    drain(0);
    check("ovr_sticky", 32'(ia.overrun), 1);
    ia.clr_ovr = 1'b1;
    @(negedge clk);
    ia.clr_ovr = 1'b0;
    check("ovr_clr", 32'(ia.overrun), 0);

    // full FIFO, pop in the push cycle
    for (int i = 1; i <= 4; i++) begin
      expect_entry(0, 0, 0, 8'(i * 17));
      send(0, 8'(i * 17), 0, 0, 1, 2'b11);
    end
    fork
      send(0, 8'h55, 0, 0, 1, 2'b11);
      begin
        repeat (154) @(negedge clk);
        pop_one(0);
        expect_entry(0, 0, 0, 8'h55);
      end
    join
    check("ovr_pop_push", 32'(ia.overrun), 0);
    drain(0);

    // reset in the middle of a byte
    send(0, 8'h77, 0, 0, 1, 2'b11);
    check("pre_rst_rdy", 32'(ia.rdy), 1);
    set_rx(0, 1'b0);
    repeat (60) @(negedge clk);
    check("mid_busy", 32'(ia.busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_rdy", 32'(ia.rdy), 0);
    check("mid_rst_busy", 32'(ia.busy), 0);
    set_rx(0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("post_rst_rdy", 32'(ia.rdy), 0);
    check("post_rst_busy", 32'(ia.busy), 0);
    check("post_rst_ovr", 32'(ia.overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
